// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, holds it for LATENCY
// cycles, then commits the write or returns read data. Optional: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
`ifdef DMEM_MISALIGN_ERR_EN
    output logic        misalign_err,
`endif
    output logic        busy
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                dv_q, dv_d;
    logic [15:0]         dout_q;
    logic                complete;
    logic                bad_q, bad_d;
    logic                mem_we, mem_re;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            dv_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dv_q    <= dv_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        bad_d    = bad_q;
        dv_d     = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    wr_d    = wr;
                    idx_d   = addr[ADDR_W:1];
                    wdata_d = data_in;
`ifdef DMEM_MISALIGN_ERR_EN
                    bad_d   = addr[0];
`else
                    bad_d   = 1'b0;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    dv_d     = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flagged (misaligned) request completes with no side effects on memory or data_out.
    assign mem_we = complete &  wr_q & ~bad_q;
    assign mem_re = complete & ~wr_q & ~bad_q;

    // Array is deliberately left out of reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (mem_re) dout_q <= mem[idx_q];
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic merr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) merr_q <= 1'b0;
        else        merr_q <= complete & bad_q;
    end
    assign misalign_err = merr_q;
    generate
        if (ADDR_W < 15) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^addr[15:ADDR_W+1];
        end
    endgenerate
`else
    // addr[0] is ignored along with the index bits above the array depth.
    generate
        if (ADDR_W < 15) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^{addr[15:ADDR_W+1], addr[0]};
        end else begin : g_unused_lo
            logic unused_addr_bits;
            assign unused_addr_bits = addr[0];
        end
    endgenerate
`endif

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign busy       = (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 instance for most scenarios,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, wr;
    logic [15:0] addr, din, dout;
    logic        dv, busy;
    logic        en_b, wr_b;
    logic [15:0] addr_b, din_b, dout_b;
    logic        dv_b, busy_b;
`ifdef DMEM_MISALIGN_ERR_EN
    logic        merr, merr_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .wr(wr), .addr(addr), .data_in(din),
        .data_out(dout), .data_valid(dv),
`ifdef DMEM_MISALIGN_ERR_EN
        .misalign_err(merr),
`endif
        .busy(busy)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
        .data_out(dout_b), .data_valid(dv_b),
`ifdef DMEM_MISALIGN_ERR_EN
        .misalign_err(merr_b),
`endif
        .busy(busy_b)
    );

    // Drives one request on the LATENCY=4 instance; returns #1 after the accepting edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        en = 1'b1; wr = w; addr = a; din = d;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Counts edges until data_valid is seen (bounded).
    task automatic wait_dv(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!dv && n < 20);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if (dv !== 1'b0)       begin failures++; $display("FAIL reset_dv got=%b exp=0", dv); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef DMEM_MISALIGN_ERR_EN
        checks++; if (merr !== 1'b0)     begin failures++; $display("FAIL reset_merr got=%b exp=0", merr); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int n;
        issue(1'b1, 16'h0010, 16'hBEEF);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_after_accept got=%b exp=1", busy); end
        wait_dv(n);
        checks++; if (n != 4)            begin failures++; $display("FAIL wr_latency got=%0d exp=4", n); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL wr_busy_at_dv got=%b exp=0", busy); end
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL wr_dout_held got=%h exp=0000", dout); end
        @(posedge clk); #1;
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL wr_dv_single got=%b exp=0", dv); end
        issue(1'b0, 16'h0010, 16'h0000);
        wait_dv(n);
        checks++; if (n != 4)            begin failures++; $display("FAIL rd_latency got=%0d exp=4", n); end
        checks++; if (dout !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=BEEF", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_reject();
        int n, pulses;
        logic [15:0] cap;
        issue(1'b1, 16'h0020, 16'h1111);
        wait_dv(n);
        @(posedge clk); #1;
        issue(1'b0, 16'h0020, 16'h0000);
        en = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h1234;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b0;
        pulses = 0; cap = 16'hxxxx;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (dv) begin pulses++; cap = dout; end
        end
        checks++; if (pulses != 1)      begin failures++; $display("FAIL rej_pulses got=%0d exp=1", pulses); end
        checks++; if (cap !== 16'h1111) begin failures++; $display("FAIL rej_read got=%h exp=1111", cap); end
        issue(1'b0, 16'h0020, 16'h0000);
        wait_dv(n);
        checks++; if (dout !== 16'h1111) begin failures++; $display("FAIL rej_reread got=%h exp=1111", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_change();
        int n;
        issue(1'b1, 16'h0030, 16'hAAAA);
        wait_dv(n);
        @(posedge clk); #1;
        issue(1'b0, 16'h0030, 16'h0000);
        addr = 16'h0040; wr = 1'b1; din = 16'hFFFF;
        wait_dv(n);
        checks++; if (dout !== 16'hAAAA) begin failures++; $display("FAIL addr_change got=%h exp=AAAA", dout); end
        wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int n;
        issue(1'b1, 16'h0050, 16'h0001);
        wait_dv(n);
        @(posedge clk); #1;
        issue(1'b1, 16'h0050, 16'h5555);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (dv !== 1'b0)       begin failures++; $display("FAIL arst_dv got=%b exp=0", dv); end
        checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL arst_dout got=%h exp=0000", dout); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 16'h0050, 16'h0000);
        wait_dv(n);
        checks++; if (dout !== 16'h0001) begin failures++; $display("FAIL arst_no_commit got=%h exp=0001", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'hC002; exp_d[1] = 16'hC004; exp_d[2] = 16'hC006;
        en_b = 1'b1; wr_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_b = 16'(2 * (k + 1)); din_b = exp_d[k];
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        wr_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr_b = 16'(2 * (k + 1));
            @(posedge clk); #1;
            checks++; if (busy_b !== 1'b1 || dv_b !== 1'b0) begin
                failures++; $display("FAIL b2b_wait[%0d] busy=%b dv=%b exp busy=1 dv=0", k, busy_b, dv_b);
            end
            @(posedge clk); #1;
            checks++; if (busy_b !== 1'b0 || dv_b !== 1'b1 || dout_b !== exp_d[k]) begin
                failures++;
                $display("FAIL b2b_done[%0d] busy=%b dv=%b data=%h exp busy=0 dv=1 data=%h",
                         k, busy_b, dv_b, dout_b, exp_d[k]);
            end
        end
        en_b = 1'b0;
        @(posedge clk); #1;
        checks++; if (dv_b !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL b2b_idle dv=%b busy=%b exp 0 0", dv_b, busy_b);
        end
    endtask

    task automatic test_misalign();
        int n;
        logic [15:0] exp_word;
        issue(1'b1, 16'h0060, 16'h1111);
        wait_dv(n);
        @(posedge clk); #1;
        issue(1'b1, 16'h0061, 16'h7777);
        wait_dv(n);
        checks++; if (n != 4) begin failures++; $display("FAIL mis_latency got=%0d exp=4", n); end
`ifdef DMEM_MISALIGN_ERR_EN
        checks++; if (merr !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", merr); end
        exp_word = 16'h1111;
`else
        exp_word = 16'h7777;
`endif
        @(posedge clk); #1;
`ifdef DMEM_MISALIGN_ERR_EN
        checks++; if (merr !== 1'b0) begin failures++; $display("FAIL mis_err_pulse got=%b exp=0", merr); end
`endif
        issue(1'b0, 16'h0060, 16'h0000);
        wait_dv(n);
        checks++; if (dout !== exp_word) begin failures++; $display("FAIL mis_word got=%h exp=%h", dout, exp_word); end
`ifdef DMEM_MISALIGN_ERR_EN
        checks++; if (merr !== 1'b0) begin failures++; $display("FAIL mis_err_aligned got=%b exp=0", merr); end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = '0; din_b = '0;
        test_reset();
        test_write_read();
        test_busy_reject();
        test_addr_change();
        test_async_reset();
        test_back_to_back();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the memory-access stage's memory request interface (enable/wr/addr/data_in/data_out).
- Accepts one word request at a time, holds it for a fixed LATENCY, then commits the write or returns read data with a one-cycle data_valid pulse.
- busy tells the memory-access stage to stall the pipeline.
- Models a slow data RAM behind the single-cycle core's memory stage.

Parameters:
- ADDR_W, 10: word-index width; depth = 2**ADDR_W 16-bit words; index = addr[ADDR_W:1].
- LATENCY, 4: cycles from the accepting edge to data_valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  request strobe; sampled only when busy=0
- wr  input  1  1 = write, 0 = read; sampled with enable
- addr  input  16  byte address; addr[0] ignored (word aligned); bits above ADDR_W ignored
- data_in  input  16  write data; sampled with enable
- data_out  output  16  read data; updated only on read completion, held otherwise
- data_valid  output  1  one-cycle completion pulse for reads and writes
- busy  output  1  high while a request is outstanding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, data_out=16'h0000, data_valid=0, busy=0.
  - Latched request discarded; a pending write is NOT committed.
  - Memory array is not cleared.
- States: IDLE, WAIT.
  - busy = (state==WAIT), combinational from the state register.
- IDLE:
  - On a rising edge with enable=1, latch wr, index and data_in; counter<=LATENCY-1; go to WAIT.
  - enable=0: stay in IDLE.
- WAIT:
  - counter!=0: counter decrements each edge.
  - counter==0 at an edge:
    - Write: mem[index]<=data_in_latched.
    - Read: data_out<=mem[index].
    - data_valid<=1, state<=IDLE.
- Latency: accepting edge E0; data_valid is high for exactly the cycle after edge E_LATENCY. LATENCY=1 gives data_valid the cycle after E1.
- data_valid deasserts at the next edge unconditionally.
- The data_valid cycle has busy=0, so a new request may be accepted at that cycle's closing edge. Peak throughput: one request per LATENCY+1 cycles.
- enable while busy=1: ignored, not queued. The requester must hold enable until it sees busy=0.
- Input changes on addr/wr/data_in while busy=1 have no effect (latched copy used).
- Write completion leaves data_out unchanged.
- Read-after-write to the same address: the read returns the newly written value, since the write commits before the read can be accepted.
- Counter width: 4 bits. No wrap: it is reloaded on every acceptance.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A request accepted with addr[0]=1 still runs the full LATENCY.
  - At completion: no memory write, data_out unchanged, data_valid=1 and misalign_err=1 for the same single cycle.
  - Aligned completions drive misalign_err=0.
- Undefined:
  - No port.
  - addr[0] is silently ignored; the access proceeds to the word at addr[ADDR_W:1].

Test Plan:
- Basic write then read: write 16'hBEEF to addr 16'h0010, wait for data_valid, then read addr 16'h0010. data_valid arrives 4 cycles after each accepting edge; data_out=16'hBEEF on the read pulse; busy high for 4 cycles per request.
- Busy rejection: while a read of addr 16'h0020 is outstanding, pulse enable with a write of 16'h1234 to 16'h0020. The write is ignored; a later read returns the prior contents; exactly one data_valid pulse per accepted request.
- Address change while busy: accept a read of 16'h0030 (contents 16'hAAAA), then drive addr=16'h0040 during WAIT. data_out=16'hAAAA.
- Async reset mid-write: accept a write of 16'h5555 to 16'h0050 (old value 16'h0001), assert rst_n=0 at cycle 2 off the clock edge. Outputs go 0 immediately; a subsequent read returns 16'h0001.
- LATENCY=1 back-to-back: hold enable=1 with reads of 16'h0002, 16'h0004, 16'h0006. data_valid pulses every 2 cycles with the correct data; busy alternates 1,0.
- Misaligned access with DMEM_MISALIGN_ERR_EN: write 16'h7777 to 16'h0061. misalign_err=1 with data_valid; a read of 16'h0060 shows the word unchanged. Without the macro, the write lands at word index 16'h30.
